// File: rtl/ringosc_counter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | ringosc_counter: ring-oscillator-clocked 32-bit counter, 8-bit window out |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module ringosc_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int CNT_WIDTH = 32;

  logic                 stop;
  logic [5:0]           shift;
  logic                 cnt_rst_n;
  logic                 osc_clk;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  assign shift     = ui_in[5:0];
  assign stop      = ui_in[6];
  assign cnt_rst_n = ~ui_in[7];

`ifdef SYNTHESIS
  localparam int RING_STAGES = 5;

  // First cell is the enable NAND; the rest are inverters closing the loop.
  (* keep = "true", dont_touch = "true" *) logic [RING_STAGES-1:0] ring;

  assign ring[0] = ~(~stop & ring[RING_STAGES-1]);

  for (genvar i = 1; i < RING_STAGES; i++) begin : g_inv
    assign ring[i] = ~ring[i-1];
  end

  assign osc_clk = ring[RING_STAGES-2];
`else
  localparam int SIM_HALF_PERIOD = 5;

  logic osc_sim = 1'b0;

  always begin
    #(SIM_HALF_PERIOD);
    osc_sim <= stop ? 1'b0 : ~osc_sim;
  end

  assign osc_clk = osc_sim;
`endif

  assign cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge osc_clk or negedge cnt_rst_n) begin
    if (!cnt_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Zero-extending before the shift makes windows past bit 31 read as 0.
  assign uo_out  = 8'({8'd0, cnt_q} >> shift);
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  logic unused_tile_inputs;
  assign unused_tile_inputs = &{1'b0, clk, rst_n, ena, uio_in};

endmodule
`default_nettype wire

// File: tb/tb_ringosc_counter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ringosc_counter: self-checking bench for ringosc_counter              |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_ringosc_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  logic       rst;
  logic       stop;
  logic [5:0] shift;

  int n_cmp = 0;
  int n_bad = 0;
  longint unsigned model_cnt = 0;

  assign ui_in = {rst, stop, shift};

  ringosc_counter dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #7 clk = ~clk;

  typedef struct {
    int         sh;
    logic [7:0] exp;
    string      name;
  } win_vec_t;

  function automatic logic [7:0] win_ref(input longint unsigned c, input int s);
    longint unsigned v;
    v = c % 64'h1_0000_0000;
    if (s >= 32) return 8'h00;
    return 8'((v / (64'd1 << s)) % 256);
  endfunction

  task automatic check(input string name, input longint unsigned act,
                       input longint unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_tol(input string name, input longint unsigned act,
                           input longint unsigned exp);
    n_cmp++;
    if (act + 1 < exp || act > exp + 1) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d +/-1", name, act, exp);
    end
  endtask

  task automatic check_ties();
    check("uio_out", uio_out, 0);
    check("uio_oe", uio_oe, 0);
  endtask

  // Keep stimulus edges 2 ns after the 5 ns oscillator grid.
  task automatic align();
    longint t;
    t = longint'($time);
    #((2 - (t % 5) + 5) % 5);
  endtask

  task automatic read_count(output longint unsigned c);
    logic [5:0] saved;
    saved = shift;
    c = 0;
    for (int k = 0; k < 4; k++) begin
      shift = 6'(8 * k);
      #1;
      c = c | (longint'(uo_out) << (8 * k));
    end
    shift = saved;
    #1;
  endtask

  task automatic run_for(input int ns);
    align();
    stop = 1'b0;
    #(ns);
    stop = 1'b1;
    #50;
    model_cnt += longint'(ns / 10);
  endtask

  task automatic check_window(input int s, input string name);
    shift = 6'(s);
    #1;
    check(name, uo_out, win_ref(model_cnt, s));
  endtask

  initial begin
    win_vec_t        tbl[$];
    longint unsigned c;
    longint unsigned c2;
    int              d;
    logic [7:0]      held;

    rst = 1'b0; stop = 1'b1; shift = 6'd0;
    #2;
    rst = 1'b1;
    #20;
    check("reset_shift0", uo_out, 8'h00);
    shift = 6'd5;  #1; check("reset_shift5", uo_out, 8'h00);
    shift = 6'd40; #1; check("reset_shift40", uo_out, 8'h00);
    check_ties();

    shift = 6'd0;
    align();
    rst = 1'b0;
    #200;
    check("stopped_after_release", uo_out, 8'h00);

    model_cnt = 0;
    run_for(1000);
    check_tol("run_1000ns", uo_out, 100);
    held = uo_out;
    for (int k = 0; k < 10; k++) begin
      rst_n = ~rst_n;
      ena   = ~ena;
      #50;
    end
    check("hold_500ns", uo_out, held);

    tbl = '{
      '{0,  8'd100, "win_s0"},
      '{2,  8'd25,  "win_s2"},
      '{6,  8'd1,   "win_s6"},
      '{7,  8'd0,   "win_s7"},
      '{32, 8'd0,   "win_s32"},
      '{63, 8'd0,   "win_s63"}
    };
    foreach (tbl[i]) begin
      shift = 6'(tbl[i].sh);
      #1;
      check(tbl[i].name, uo_out, tbl[i].exp);
    end

    shift = 6'd0;
    run_for(2560);
    tbl = '{
      '{0,  8'h64, "wrap_s0"},
      '{8,  8'h01, "wrap_s8"},
      '{1,  8'hB2, "wrap_s1"},
      '{24, 8'h00, "wrap_s24"}
    };
    foreach (tbl[i]) begin
      shift = 6'(tbl[i].sh);
      #1;
      check(tbl[i].name, uo_out, tbl[i].exp);
    end
    read_count(c);
    check("count_356", c, 356);
    check_ties();

    // Reset while running clears at once and holds while the ring keeps going.
    shift = 6'd0;
    align();
    stop = 1'b0;
    #200;
    align();
    rst = 1'b1;
    #1;
    check("reset_midrun_immediate", uo_out, 8'h00);
    #99;
    check("reset_midrun_hold", uo_out, 8'h00);
    align();
    rst = 1'b0;
    #300;
    stop = 1'b1;
    #50;
    read_count(c);
    check_tol("after_reset_300ns", c, 30);
    model_cnt = 30;

    // Joint release of reset and stop counts from zero.
    align();
    rst = 1'b1;
    #20;
    check("joint_reset", uo_out, 8'h00);
    align();
    rst = 1'b0;
    stop = 1'b0;
    #200;
    stop = 1'b1;
    #50;
    model_cnt = 20;
    read_count(c);
    check("joint_release", c, 20);

    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 4) == 0) begin
        align();
        rst = 1'b1;
        #20;
        rst = 1'b0;
        model_cnt = 0;
      end
      d = 10 * int'($urandom_range(1, 120));
      run_for(d);
      rst_n = 1'($urandom);
      ena   = 1'($urandom);
      for (int k = 0; k < 3; k++) begin
        check_window(int'($urandom_range(0, 63)), "rand_window");
      end
      check_window(int'($urandom_range(0, 3)), "rand_low_window");
      if (it % 6 == 0) begin
        read_count(c);
        check("rand_count", c, model_cnt % 64'h1_0000_0000);
        #300;
        read_count(c2);
        check("rand_frozen", c2, model_cnt % 64'h1_0000_0000);
        check_ties();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ringosc_counter.md
# ringosc_counter

Free-running ring-oscillator frequency counter for a Tiny Tapeout tile. An on-chip ring oscillator clocks a 32-bit ripple-safe binary counter, which can be frozen and cleared from the user inputs. A selectable 8-bit window of the count is presented on the dedicated outputs. The block is the tile top level (`tt_um_urish_ringosc_cnt`) and needs no external clock.

## Interface
Parameters (internal localparams, not overridable at the tile boundary):
- CNT_WIDTH, 32, counter width in bits.
- RING_STAGES, 5, inverting stages in the ring (odd; includes the enable NAND).
- SIM_HALF_PERIOD, 5 ns, oscillator half period used by the behavioural simulation model.

Ports:
- Clocking/reset: one clock; reset is asynchronous and active-low.
- clk  in  1  tile clock port; standard tile port, not used by the logic. The one clock is the internal ring-oscillator output `osc_clk`.
- rst_n  in  1  tile reset port; standard tile port, ignored. The counter's asynchronous active-low reset is `cnt_rst_n = ~ui_in[7]`.
- ena  in  1  tile enable; ignored.
- ui_in[5:0]  in  6  `shift`: LSB index of the output window.
- ui_in[6]  in  1  `stop`: 1 halts the oscillator and freezes the count.
- ui_in[7]  in  1  `reset`: 1 asynchronously clears the counter.
- uo_out  out  8  `cnt[shift +: 8]`, zero-filled above bit 31.
- uio_in  in  8  unused.
- uio_out  out  8  constant 0.
- uio_oe  out  8  constant 0.

## Operation
- Oscillator:
  - A closed loop of RING_STAGES inverting cells. The first cell is a NAND of `~stop` and the loop feedback.
  - Mark the cells keep/dont_touch so synthesis does not collapse the loop.
  - When stop=1 the loop is held static and `osc_clk` stops toggling.
  - Behavioural model (when SYNTHESIS is undefined): `osc_clk` toggles every SIM_HALF_PERIOD while stop=0 and is held at 0 while stop=1. `osc_clk` initialises to 0.
- Counter:
  - `cnt[31:0]` increments by 1 on each rising edge of `osc_clk`.
  - It wraps from 0xFFFF_FFFF to 0.
  - While `cnt_rst_n`=0 (reset=1), `cnt` is forced to 0 immediately, independent of `osc_clk`, and held there.
- Output window:
  - Combinational: `uo_out[i] = cnt[shift+i]` when shift+i ≤ 31, else 0.
  - shift 0 gives the 8 LSBs; shift 24 gives the 8 MSBs; shift ≥ 32 gives 0x00.
  - `uo_out` is not registered, so a changing shift takes effect at once.
- Reset values: `cnt`=0, so `uo_out`=0x00 for any shift. `uio_out`=0x00 and `uio_oe`=0x00 at all times.
- Reading a count: assert stop, wait, then read. Reading while running is allowed but may catch a transitioning value.

## Timing
- Counter latency is one `osc_clk` rising edge per increment. Simulation rate is 1 count per 2×SIM_HALF_PERIOD (10 ns).
- Reset assertion clears the count asynchronously. After reset is released, the count starts at the first `osc_clk` rising edge.
- Reset and stop are independent:
  - reset=1, stop=0: oscillator runs, count stays 0.
  - reset=1, stop=1: count is 0 and held.
- Stop assertion: at most one further increment may occur (a partial edge in flight). The count is then constant for as long as stop=1.
- Stop release: counting resumes within one oscillator period, with no loss of the held value.
- Simultaneous reset release and stop release: the count starts from 0.
- No setup/hold relationship to the tile clock `clk`. All ui_in are treated as asynchronous.

## Test plan
- Reset: reset=1, stop=1, shift=0 for 20 ns -> uo_out=0x00. Repeat with shift=5 and shift=40 -> 0x00.
- Run/freeze:
  - Release reset with stop=1, wait 200 ns -> 0x00.
  - Set stop=0 for 1000 ns, then stop=1, wait 50 ns.
  - shift=0 -> 100 (0x64), ±1 allowed for the stop edge.
  - Hold stop=1 a further 500 ns -> value unchanged.
- Window selection: with the frozen count of 100:
  - shift=2 -> 25 (0x19).
  - shift=6 -> 1.
  - shift=7 -> 0.
  - shift=32 -> 0.
  - shift=63 -> 0.
- Resume and wrap of the window:
  - Run stop=0 a further 2560 ns (total count ≈ 356 = 0x164), then stop.
  - shift=0 -> 0x64.
  - shift=8 -> 0x01.
- Reset mid-run: with stop=0 counting, assert reset -> uo_out=0 within the same timestep. Hold 100 ns -> still 0. Release for 300 ns, then stop -> 30 ±1.
- Tie-offs: throughout all of the above, uio_out=0x00 and uio_oe=0x00. Toggling clk, rst_n and ena has no effect on uo_out.
